// File: rtl/fnd_pkg.sv
// Shared types, constants and helpers for the FND value generator.
package fnd_pkg;

    // Code sent to the scan driver for a suppressed leading digit.
    localparam logic [3:0] BLANK_CODE = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT
    } state_t;

    // Largest value representable in the given number of decimal digits.
    function automatic longint max_dec(input int digits);
        longint r;
        r = 1;
        for (int i = 0; i < digits; i++) begin
            r = r * 10;
        end
        return r - 1;
    endfunction

    // Pass a digit through, or replace it with the blank code.
    function automatic logic [3:0] blank_digit(input logic [3:0] d, input logic keep);
        return keep ? d : BLANK_CODE;
    endfunction

endpackage

// File: rtl/bcd_dd_step.sv
// One double-dabble iteration: add 3 to every nibble >= 5, then shift the
// next binary bit into the ones digit.
module bcd_dd_step #(
    parameter int DIGITS = 4
) (
    input  logic [4*DIGITS-1:0] bcd_in,
    input  logic                bin_msb,
    output logic [4*DIGITS-1:0] bcd_out,
    output logic                carry_out
);

    logic [4*DIGITS-1:0] adj;

    // Per-nibble correction so each digit carries correctly after doubling.
    always_comb begin
        adj = bcd_in;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_in[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd_in[4*i +: 4] + 4'd3;
            end
        end
    end

    assign bcd_out   = {adj[4*DIGITS-2:0], bin_msb};
    // Bit pushed out of the top digit: the value no longer fits in DIGITS.
    assign carry_out = adj[4*DIGITS-1];

endmodule

// File: rtl/fnd_value_gen.sv
// Converts fan state or run-timer seconds into blanked, saturated packed BCD
// for the FND multiplexer; reconverts only when the selected source changes.
module fnd_value_gen
    import fnd_pkg::*;
#(
    parameter int STATE_W  = 3,
    parameter int VAL_W    = 14,
    parameter int DIGITS   = 4,
    parameter int BLANK_EN = 1
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_mode,
    input  logic [STATE_W-1:0]  i_fanState,
    input  logic [VAL_W-1:0]    i_timer,
    output logic [4*DIGITS-1:0] o_digits,
    output logic                o_valid,
    output logic                o_ovf,
    output logic                o_busy
);

    localparam int               CNT_W   = $clog2(VAL_W + 1);
    localparam logic [VAL_W-1:0] MAX_VAL = VAL_W'(max_dec(DIGITS));

    state_t              state, state_nxt;
    logic [VAL_W-1:0]    sel;
    logic [VAL_W:0]      snapshot;
    logic                force_flag;
    logic                start;

    logic [VAL_W-1:0]    shift_reg;
    logic [4*DIGITS-1:0] bcd_reg, bcd_step;
    logic                bcd_carry, bcd_lost;
    logic [CNT_W-1:0]    cnt;

    logic                ovf_c;
    logic [4*DIGITS-1:0] commit_digits;
    logic                lead;

    assign sel    = i_mode ? i_timer : VAL_W'(i_fanState);
    // Mode is part of the snapshot so a mode switch with an equal value still converts.
    assign start  = force_flag || ({i_mode, sel} != snapshot);
    assign o_busy = (state != IDLE);

    bcd_dd_step #(
        .DIGITS (DIGITS)
    ) u_step (
        .bcd_in    (bcd_reg),
        .bin_msb   (shift_reg[VAL_W-1]),
        .bcd_out   (bcd_step),
        .carry_out (bcd_carry)
    );

    // Sequencing: capture in IDLE, VAL_W shift edges, one commit edge.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (cnt == CNT_W'(1)) state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset) state <= IDLE;
        else         state <= state_nxt;
    end

    // Saturation and leading-zero blanking of the finished conversion.
    always_comb begin
        ovf_c         = (snapshot[VAL_W-1:0] > MAX_VAL) || bcd_lost;
        commit_digits = bcd_reg;
        lead          = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (bcd_reg[4*i +: 4] != 4'd0) lead = 1'b0;
            commit_digits[4*i +: 4] = blank_digit(bcd_reg[4*i +: 4], !lead || (BLANK_EN == 0));
        end
        if (ovf_c) commit_digits = {DIGITS{4'h9}};
    end

    // Snapshot, forced-conversion flag and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            snapshot   <= '0;
            force_flag <= 1'b1;
            o_digits   <= '0;
            o_ovf      <= 1'b0;
            o_valid    <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            if (state == IDLE && start) begin
                snapshot   <= {i_mode, sel};
                force_flag <= 1'b0;
            end
            if (state == COMMIT) begin
                o_digits <= commit_digits;
                o_ovf    <= ovf_c;
                o_valid  <= 1'b1;
            end
        end
    end

    // Conversion datapath; reloaded at every capture so it needs no reset.
    always_ff @(posedge i_clk) begin
        case (state)
            IDLE: begin
                if (start) begin
                    shift_reg <= sel;
                    bcd_reg   <= '0;
                    cnt       <= CNT_W'(VAL_W);
                    bcd_lost  <= 1'b0;
                end
            end
            SHIFT: begin
                shift_reg <= shift_reg << 1;
                bcd_reg   <= bcd_step;
                cnt       <= cnt - 1'b1;
                bcd_lost  <= bcd_lost | bcd_carry;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_fnd_value_gen.sv
// Scoreboard bench for fnd_value_gen (DIGITS=4, VAL_W=14, BLANK_EN=1).
module tb_fnd_value_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        mode;
    logic [2:0]  fan;
    logic [13:0] timer;
    logic [15:0] digits;
    logic        valid, ovf, busy;

    fnd_value_gen #(
        .STATE_W  (3),
        .VAL_W    (14),
        .DIGITS   (4),
        .BLANK_EN (1)
    ) dut (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_mode     (mode),
        .i_fanState (fan),
        .i_timer    (timer),
        .o_digits   (digits),
        .o_valid    (valid),
        .o_ovf      (ovf),
        .o_busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] digits;
        logic        ovf;
        int          due;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          passes = 0;
    int          cyc = 0;
    int          n_push = 0;
    int          n_valid = 0;
    logic [14:0] last_key;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    endtask

    // Decimal display the way a person would write it on a 4-digit panel.
    function automatic exp_t model(input int v, input int due);
        exp_t e;
        int   p;
        e.due    = due;
        e.digits = '0;
        if (v > 9999) begin
            e.digits = 16'h9999;
            e.ovf    = 1'b1;
        end else begin
            e.ovf = 1'b0;
            p = 1;
            for (int i = 0; i < 4; i++) begin
                if (i > 0 && v < p) e.digits[4*i +: 4] = 4'hF;
                else                e.digits[4*i +: 4] = 4'((v / p) % 10);
                p = p * 10;
            end
        end
        return e;
    endfunction

    // Drive inputs; expect a conversion only if {mode, selected value} changed.
    task automatic apply(input logic m, input logic [2:0] f, input logic [13:0] t, input bit timed);
        logic [14:0] key;
        int          v;
        mode  = m;
        fan   = f;
        timer = t;
        v   = m ? int'(t) : int'(f);
        key = {m, 14'(v)};
        if (key != last_key) begin
            sb.push_back(model(v, timed ? cyc + 16 : -1));
            n_push++;
            last_key = key;
        end
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((sb.size() != 0 || busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("drained_queue", sb.size(), 0);
        chk("idle_after_drain", busy, 0);
        repeat (2) @(negedge clk);
    endtask

    // Monitor: every o_valid pulse consumes one expected commit.
    always @(negedge clk) begin : mon
        exp_t e;
        if (valid === 1'b1) begin
            n_valid++;
            if (sb.size() == 0) begin
                chk("unexpected_valid", valid, 0);
            end else begin
                e = sb.pop_front();
                chk("digits", digits, e.digits);
                chk("ovf", ovf, e.ovf);
                if (e.due >= 0) chk("latency", cyc, e.due);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int          base;
        logic        m;
        logic [2:0]  f;
        logic [13:0] t;

        rst      = 1'b1;
        mode     = 1'b0;
        fan      = 3'd0;
        timer    = 14'd0;
        last_key = 15'h7FFF;
        repeat (3) @(negedge clk);
        chk("rst_digits", digits, 16'h0000);
        chk("rst_valid", valid, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_busy", busy, 0);

        // Forced first conversion after reset, then silence while idle.
        rst = 1'b0;
        apply(1'b0, 3'd0, 14'd0, 1'b1);
        @(negedge clk);
        chk("busy_after_release", busy, 1);
        drain(60);
        repeat (30) @(negedge clk);
        chk("single_pulse_after_reset", n_valid, 1);

        // Fan state, then same value in timer mode.
        apply(1'b0, 3'd3, 14'd0, 1'b1);
        drain(60);
        apply(1'b1, 3'd3, 14'd3, 1'b1);
        drain(60);

        // Timer values, boundary and saturation.
        apply(1'b1, 3'd3, 14'd1234, 1'b1);  drain(60);
        apply(1'b1, 3'd3, 14'd905, 1'b1);   drain(60);
        apply(1'b1, 3'd3, 14'd9999, 1'b1);  drain(60);
        apply(1'b1, 3'd3, 14'd10000, 1'b1); drain(60);
        apply(1'b1, 3'd3, 14'd12000, 1'b1); drain(60);
        apply(1'b1, 3'd3, 14'd7, 1'b1);     drain(60);

        // Change during conversion: both values get committed, in order.
        base = n_valid;
        apply(1'b1, 3'd3, 14'd1234, 1'b1);
        repeat (5) @(negedge clk);
        apply(1'b1, 3'd3, 14'd42, 1'b0);
        drain(100);
        chk("two_pulses_on_midshift_change", n_valid - base, 2);

        // Reset mid-conversion aborts it, then forces a fresh one.
        mode     = 1'b1;
        timer    = 14'd5678;
        last_key = {1'b1, 14'd5678};
        repeat (6) @(negedge clk);
        chk("busy_mid_shift", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_digits", digits, 16'h0000);
        chk("midrst_valid", valid, 0);
        chk("midrst_ovf", ovf, 0);
        chk("midrst_busy", busy, 0);
        rst = 1'b0;
        sb.push_back(model(5678, cyc + 16));
        n_push++;
        drain(60);

        // Randomized sources, including steady (no-change) repeats.
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 4) == 0) begin
                apply(mode, fan, timer, 1'b1);
                repeat (20) @(negedge clk);
            end else begin
                m = 1'($urandom_range(0, 1));
                f = 3'($urandom);
                if ($urandom_range(0, 3) == 0) t = 14'($urandom_range(0, 16383));
                else                           t = 14'($urandom_range(0, 9999));
                apply(m, f, t, 1'b1);
            end
            drain(80);
        end

        repeat (20) @(negedge clk);
        chk("valid_total", n_valid, n_push);
        chk("queue_empty_at_end", sb.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/fnd_value_gen.md
Name: fnd_value_gen

Overview:
Parametrised successor to the fan-state digit mapper. It converts a selectable binary source into DIGITS packed BCD digits for the FND scan driver:
- mode 0: fan state
- mode 1: run-timer seconds

Conversion is iterative double-dabble, one bit per clock. The block adds change detection, saturation, leading-zero blanking and a commit strobe. It sits between the fan FSM/timer and the FND multiplexer.

Parameters:
STATE_W, 3, width of fan-state input.
VAL_W, 14, width of timer input and of the conversion datapath. Must satisfy 2^VAL_W-1 >= 10^DIGITS-1 and VAL_W >= STATE_W.
DIGITS, 4, number of BCD digits output.
BLANK_EN, 1, 1 = replace leading-zero digits with BLANK_CODE.

Ports:
i_clk  in  1  system clock, all logic on rising edge.
i_reset  in  1  synchronous, active-high reset.
i_mode  in  1  0 = display fan state, 1 = display timer.
i_fanState  in  STATE_W  fan state, zero-extended to VAL_W.
i_timer  in  VAL_W  timer value in seconds.
o_digits  out  4*DIGITS  packed digits; digit 0 (ones) in [3:0].
o_valid  out  1  one-cycle pulse on the cycle after o_digits updates.
o_ovf  out  1  selected value exceeded 10^DIGITS-1 at last commit.
o_busy  out  1  high while state is not IDLE.

Behaviour:
- One clock (i_clk). Reset i_reset is synchronous and active-high.
- Source select: sel = i_mode ? i_timer : zero-extended i_fanState.
- States:
  - IDLE: if force_flag=1 or {i_mode, sel} differs from the snapshot, then on the edge:
    - snapshot <= {i_mode, sel}
    - shift reg <= sel, BCD reg <= 0, bit count <= VAL_W
    - force_flag <= 0, go to SHIFT.
    - Otherwise stay in IDLE.
  - SHIFT: each edge, add 3 to every BCD nibble >= 5, then shift {bcd, bin} left by 1 and decrement the count. After exactly VAL_W SHIFT edges, go to COMMIT.
  - COMMIT: one edge. Registers o_digits, o_ovf and o_valid=1, then returns to IDLE.
- o_valid is high for exactly the one cycle following the COMMIT edge; low otherwise.
- Latency: capture edge E0, shifts E1..E_VAL_W, commit E_(VAL_W+1). With default VAL_W=14, outputs are valid 15 edges after capture.
- Saturation: if snapshot value > 10^DIGITS-1, commit all digits = 9 and o_ovf=1; otherwise o_ovf=0. Compare against a constant derived from DIGITS.
- Blanking (BLANK_EN=1): scan from the most significant digit; every zero digit above the first non-zero digit becomes BLANK_CODE (4'hF). Digit 0 is never blanked. Saturated output is never blanked. BLANK_EN=0 outputs raw BCD.
- Input changes during SHIFT/COMMIT are ignored. They are detected on the return to IDLE because the snapshot then differs. This gives one extra conversion, with no lost final value.
- A mode switch with an equal numeric value still triggers conversion, because the mode is part of the snapshot.
- A steady input produces no further o_valid pulses.
- Reset, at any time including mid-SHIFT:
  - state = IDLE
  - o_digits = 0, o_valid = 0, o_ovf = 0, o_busy = 0
  - snapshot = 0, force_flag = 1
- The first IDLE cycle after reset therefore always converts.
- o_busy is combinational from state (state != IDLE).

Decomposition:
- Package fnd_pkg:
  - BLANK_CODE = 4'hF
  - state enum {IDLE, SHIFT, COMMIT}
  - constant function max_dec(DIGITS) = 10^DIGITS-1
  - helper function for blanking
- One natural sub-module: bcd_dd_step. Purely combinational add-3-and-shift across DIGITS nibbles, parametrised by DIGITS. It is instantiated once inside the SHIFT datapath.

Test Plan (DIGITS=4, VAL_W=14, BLANK_EN=1):
1. Release reset with i_mode=0, i_fanState=0 -> o_busy rises; 15 edges after capture, o_digits=16'hFFF0 and o_valid pulses exactly once; no further pulses while idle.
2. i_mode=0, i_fanState 0->3 -> o_digits=16'hFFF3 after one conversion; then i_mode=1 with i_timer=3 -> new conversion, o_valid pulses, o_digits stays 16'hFFF3.
3. i_mode=1, i_timer=1234 -> 16'h1234, o_ovf=0; i_timer=905 -> 16'hF905; i_timer=9999 -> 16'h9999, o_ovf=0.
4. i_timer=12000 -> o_digits=16'h9999, o_ovf=1; then i_timer=7 -> 16'hFFF7, o_ovf=0.
5. i_timer=1234, then change to 42 on the 5th SHIFT cycle -> first commit 16'h1234, second commit 16'hFF42; exactly two o_valid pulses.
6. Assert i_reset for 1 cycle mid-SHIFT -> next cycle all outputs 0 and o_busy=0; then a forced conversion of the current input completes with one o_valid pulse.
